sub_szeregowy: RTL
==================

Name: sub_szeregowy

Overview:
Bit-serial N-bit subtractor controller built around one 1-bit full-subtractor cell (difference/borrow). It latches two operands and an initial borrow on a start request, then steps the single cell LSB-first for N cycles. The borrow is carried in a flip-flop between steps. On completion it publishes the N-bit difference and final borrow with a one-cycle done pulse. It is the sequencer that lets the serce arithmetic path reuse the 1-bit cell for multi-bit words.

Parameters:
N, 8, operand/result width in bits; legal range 1..32.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request to begin a subtraction; sampled on rising edge.
A  input  N  minuend; sampled only in the cycle start is accepted.
B  input  N  subtrahend; sampled only in the cycle start is accepted.
C_wej  input  1  initial borrow-in; sampled only in the cycle start is accepted.
Q  output  N  registered difference, A - B - C_wej mod 2^N.
C_wyj  output  1  registered final borrow-out; 1 when A < B + C_wej (unsigned).
busy  output  1  high while a subtraction is in progress.
done  output  1  one-cycle pulse when Q/C_wyj have just been updated.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1 the block enters state IDLE. Q=0, C_wyj=0, busy=0, done=0. The internal shift registers, borrow flip-flop and bit counter clear to 0. rst has priority over start and over any in-progress operation.
- Reset mid-operation: the operation is abandoned. Q and C_wyj read 0, not partial results. No done pulse is produced.
- Bit cell, per step i:
  - d = a_i ^ b_i ^ br
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
- Internal state:
  - Operand shift registers sa, sb: N bits each, shifted right one bit per step. a_i/b_i are taken from bit 0.
  - Result shift register sr: N bits. d enters at the MSB and sr shifts right, so after N steps bit 0 of sr holds step 0.
  - Counter cnt: width ceil(log2(N+1)).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - On start=1: load sa=A, sb=B, br=C_wej, cnt=0, and go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - busy=1.
  - Every edge performs one step and cnt increments.
  - At the edge where cnt reaches N-1 (the Nth step):
    - load Q with the final shifted sr value;
    - load C_wyj with br_next;
    - go to DONE.
  - start is ignored in RUN; A, B and C_wej may change freely.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - If start=1 in this cycle, operands are accepted exactly as in IDLE and the FSM goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Latency: start is sampled at edge E0. busy is high from after E0 through EN. done is high between EN and EN+1, i.e. N cycles after acceptance. Throughput is one result per N+1 cycles when start is held high.
- Output stability: Q and C_wyj change only at the completion edge or on reset. They hold their value through IDLE and through subsequent RUN phases until the next completion.
- N=1: RUN lasts exactly one cycle. The completion condition cnt==0 holds on the first step.
- Wrap-around: the result is modulo 2^N. C_wyj indicates the borrow beyond the MSB.

Test Plan:
- N=8, A=5, B=3, C_wej=0, start pulse -> busy high for 8 cycles; done 8 cycles after acceptance; Q=0x02, C_wyj=0.
- N=8, A=3, B=5, C_wej=0 -> Q=0xFE, C_wyj=1. Then A=0, B=0, C_wej=1 -> Q=0xFF, C_wyj=1. Then A=0xFF, B=0x0F, C_wej=1 -> Q=0xEF, C_wyj=0.
- Start asserted and operands changed to A=0xAA, B=0x55 at cycle 3 of a RUN computing 9-4 -> ignored; Q=0x05 at done; no second done follows.
- start held high continuously with alternating operands (9-4, then 0x10-0x20) -> done pulses exactly 9 cycles apart; Q=0x05 then Q=0xF0 with C_wyj=1; busy low only in done cycles.
- rst asserted at cycle 4 of RUN -> next edge: Q=0, C_wyj=0, busy=0, done=0; no done pulse; a fresh start afterwards computes 7-7 -> Q=0, C_wyj=0.
- N=1 instance, full sweep of A, B, C_wej (8 combinations) -> Q and C_wyj match the 1-bit full-subtractor truth table; done 1 cycle after each acceptance.

Source files
------------

// File: rtl/sub_szeregowy.sv
// Bit-serial N-bit subtractor: one full-subtractor cell stepped LSB-first for N cycles,
// borrow held in a flip-flop between steps, result published with a one-cycle done pulse.
module sub_szeregowy #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_wej,
  output logic [N-1:0] Q,
  output logic         C_wyj,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state_o
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  sa_q, sb_q, sr_q, q_q;
  logic          br_q, cwyj_q, busy_q, done_q;
  logic [CW-1:0] cnt_q;

  logic          a_bit, b_bit, d_bit, br_next;
  logic [N-1:0]  sr_shift;

  // The single full-subtractor cell plus the result shifter feeding it.
  always_comb begin
    a_bit    = sa_q[0];
    b_bit    = sb_q[0];
    d_bit    = a_bit ^ b_bit ^ br_q;
    br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
    sr_shift = sr_q >> 1;
    sr_shift[N-1] = d_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      q_q     <= '0;
      br_q    <= 1'b0;
      cwyj_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            sa_q    <= A;
            sb_q    <= B;
            br_q    <= C_wej;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sr_q  <= sr_shift;
          br_q  <= br_next;
          cnt_q <= cnt_q + CW'(1);
          // Nth step: publish directly from the cell so the result is ready with done.
          if (cnt_q == LAST) begin
            q_q     <= sr_shift;
            cwyj_q  <= br_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Q           = q_q;
  assign C_wyj       = cwyj_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
